fifo_write_arbiter: RTL and testbench



---
 rtl/fifo_write_arbiter.sv | 114 +++++++++++
 tb/tb_fifo_write_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-based arbiter that shares one FIFO write port among N_REQ producers.
// An owner keeps the port for up to MAX_BURST words, until it marks last, or until it drops its request.
module fifo_write_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    input  logic                    fifo_full,
    output logic [N_REQ-1:0]        ack,
    output logic                    write_flag,
    output logic [DATA_W-1:0]       data_write,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                    busy
);

    localparam int OW = $clog2(N_REQ);
    localparam int BW = $clog2(MAX_BURST) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] last_grant_q, last_grant_d;
    logic [BW-1:0] beat_q, beat_d;

    logic [OW-1:0]     pick;
    logic              pick_found;
    logic [BW-1:0]     beat_inc;
    logic [DATA_W-1:0] owner_data;
    logic              owner_req;
    logic              owner_last;

    // Rotating priority search: first pending requester after the previous owner.
    always_comb begin
        pick       = last_grant_q;
        pick_found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            int idx;
            idx = (int'(last_grant_q) + k) % N_REQ;
            if (!pick_found && req[idx]) begin
                pick_found = 1'b1;
                pick       = OW'(idx);
            end
        end
    end

    always_comb begin
        owner_data = req_data[int'(owner_q)*DATA_W +: DATA_W];
        owner_req  = req[owner_q];
        owner_last = req_last[owner_q];
        beat_inc   = beat_q + BW'(1);
    end

    // The word in flight during a reset cycle is dropped, hence the rst_n term.
    always_comb begin
        write_flag = rst_n && (state_q == BURST) && owner_req && !fifo_full;
        ack        = write_flag ? (N_REQ'(1) << owner_q) : '0;
        data_write = write_flag ? owner_data : '0;
        owner      = owner_q;
        busy       = (state_q == BURST);
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        beat_d       = beat_q;
        case (state_q)
            IDLE: begin
                if (pick_found && !fifo_full) begin
                    state_d = BURST;
                    owner_d = pick;
                    beat_d  = '0;
                end
            end
            BURST: begin
                if (!owner_req) begin
                    state_d      = IDLE;
                    last_grant_d = owner_q;
                end else if (!fifo_full) begin
                    beat_d = beat_inc;
                    if (owner_last || (beat_inc == BW'(MAX_BURST))) begin
                        state_d      = IDLE;
                        last_grant_d = owner_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_grant_q <= OW'(N_REQ - 1);
            beat_q       <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            beat_q       <= beat_d;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: per-requester word queues drive the DUT, a cycle-level
// reference model is compared every cycle, and directed scenarios pin exact write timing.
module tb_fifo_write_arbiter;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int MB  = 4;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } word_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [N-1:0]        req = '0;
    logic [N*DW-1:0]     req_data = '0;
    logic [N-1:0]        req_last = '0;
    logic                fifo_full = 1'b0;
    logic [N-1:0]        ack;
    logic                write_flag;
    logic [DW-1:0]       data_write;
    logic [1:0]          owner;
    logic                busy;

    fifo_write_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_last(req_last),
        .fifo_full(fifo_full), .ack(ack), .write_flag(write_flag), .data_write(data_write),
        .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    word_t      wq [N][$];
    logic [N-1:0] en = '1;
    logic [N-1:0] ack_seen = '0;

    int          log_cyc [$];
    int          log_own [$];
    logic [DW-1:0] log_dat [$];

    // Reference model: who holds the port, who held it last, and words written this grant.
    int m_busy = 0;
    int m_owner = 0;
    int m_last = N - 1;
    int m_words = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    endtask

    function automatic void drive();
        for (int i = 0; i < N; i++) begin
            if (en[i] && wq[i].size() > 0) begin
                req[i] = 1'b1;
                req_data[i*DW +: DW] = wq[i][0].data;
                req_last[i] = wq[i][0].last;
            end else begin
                req[i] = 1'b0;
                req_last[i] = 1'b0;
            end
        end
    endfunction

    task automatic applyStimulus();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (ack_seen[i] && wq[i].size() > 0) void'(wq[i].pop_front());
        drive();
    endtask

    task automatic waitLog(input int n, input int budget, input string name);
        int b;
        b = budget;
        while (log_cyc.size() < n && b > 0) begin
            applyStimulus();
            b--;
        end
        if (log_cyc.size() < n) checkOutput({name, "_timeout"}, 64'(log_cyc.size()), 64'(n));
    endtask

    task automatic doReset();
        for (int i = 0; i < N; i++) wq[i].delete();
        en = '1;
        fifo_full = 1'b0;
        rst_n = 1'b0;
        drive();
        applyStimulus();
        applyStimulus();
        rst_n = 1'b1;
        log_cyc.delete();
        log_own.delete();
        log_dat.delete();
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_busy = 0; m_owner = 0; m_last = N - 1; m_words = 0;
        end else if (m_busy == 0) begin
            if (req != '0 && !fifo_full) begin
                for (int k = 1; k <= N; k++) begin
                    if (m_busy == 0 && req[(m_last + k) % N]) begin
                        m_owner = (m_last + k) % N;
                        m_busy = 1;
                        m_words = 0;
                    end
                end
            end
        end else if (!req[m_owner]) begin
            m_busy = 0;
            m_last = m_owner;
        end else if (!fifo_full) begin
            m_words++;
            if (req_last[m_owner] || m_words == MB) begin
                m_busy = 0;
                m_last = m_owner;
            end
        end
    end

    // Per-cycle comparison against the model, plus a log of every word handed to the FIFO.
    always @(negedge clk) begin
        logic          exp_wr;
        logic [N-1:0]  exp_ack;
        logic [DW-1:0] exp_dat;
        exp_wr  = rst_n && (m_busy != 0) && req[m_owner] && !fifo_full;
        exp_ack = exp_wr ? N'(1 << m_owner) : '0;
        exp_dat = exp_wr ? req_data[m_owner*DW +: DW] : '0;
        checkOutput("write_flag", 64'(write_flag), 64'(exp_wr));
        checkOutput("ack", 64'(ack), 64'(exp_ack));
        checkOutput("data_write", 64'(data_write), 64'(exp_dat));
        checkOutput("owner", 64'(owner), 64'(m_owner));
        checkOutput("busy", 64'(busy), 64'(m_busy != 0));
        ack_seen = ack;
        if (write_flag) begin
            log_cyc.push_back(cyc);
            log_own.push_back(int'(owner));
            log_dat.push_back(data_write);
        end
    end

    initial begin
        int base;
        int deltas [6];
        deltas = '{0, 1, 2, 3, 5, 6};

        // Single requester, six words: bursts of 4 then 2 with one idle cycle between.
        doReset();
        @(negedge clk);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_owner", 64'(owner), 64'd0);
        checkOutput("reset_ack", 64'(ack), 64'd0);
        for (int w = 0; w < 6; w++) wq[2].push_back('{last: (w == 5), data: DW'(32'hA0 + w)});
        applyStimulus();
        waitLog(6, 30, "single");
        if (log_cyc.size() >= 6) begin
            base = log_cyc[0];
            for (int w = 0; w < 6; w++) begin
                checkOutput("single_data", 64'(log_dat[w]), 64'(32'hA0 + w));
                checkOutput("single_owner", 64'(log_own[w]), 64'd2);
                checkOutput("single_timing", 64'(log_cyc[w] - base), 64'(deltas[w]));
            end
        end

        // All four with one-word bursts: order 0,1,2,3, a write every other cycle.
        doReset();
        for (int i = 0; i < N; i++) wq[i].push_back('{last: 1'b1, data: DW'(32'hC0 + i)});
        drive();
        waitLog(4, 30, "rr");
        if (log_cyc.size() >= 4) begin
            for (int i = 0; i < 4; i++) checkOutput("rr_order", 64'(log_own[i]), 64'(i));
            for (int i = 1; i < 4; i++) checkOutput("rr_gap", 64'(log_cyc[i] - log_cyc[i-1]), 64'd2);
        end

        // FIFO full for 3 cycles after requester 1's second word; burst still ends at 4 words.
        doReset();
        for (int w = 0; w < 6; w++) wq[1].push_back('{last: 1'b0, data: DW'(32'hD0 + w)});
        drive();
        waitLog(2, 20, "stall_pre");
        fifo_full = 1'b1;
        applyStimulus();
        applyStimulus();
        applyStimulus();
        fifo_full = 1'b0;
        waitLog(5, 20, "stall_post");
        if (log_cyc.size() >= 5) begin
            checkOutput("stall_gap", 64'(log_cyc[2] - log_cyc[1]), 64'd4);
            checkOutput("stall_w4", 64'(log_cyc[3] - log_cyc[2]), 64'd1);
            checkOutput("stall_idle", 64'(log_cyc[4] - log_cyc[3]), 64'd2);
            checkOutput("stall_data", 64'(log_dat[3]), 64'(32'hD3));
        end

        // Withdrawal by requester 3 after one word; requester 0 is next even with 1 pending.
        doReset();
        wq[0].push_back('{last: 1'b1, data: 32'hE0});
        drive();
        waitLog(1, 20, "wd_warm");
        for (int w = 0; w < 3; w++) wq[3].push_back('{last: 1'b0, data: DW'(32'hF0 + w)});
        waitLog(2, 20, "wd_first");
        en[3] = 1'b0;
        wq[0].push_back('{last: 1'b1, data: 32'hE1});
        wq[1].push_back('{last: 1'b1, data: 32'hE2});
        drive();
        waitLog(3, 20, "wd_next");
        if (log_cyc.size() >= 3) begin
            checkOutput("wd_own3", 64'(log_own[1]), 64'd3);
            checkOutput("wd_next_own", 64'(log_own[2]), 64'd0);
            checkOutput("wd_next_dat", 64'(log_dat[2]), 64'(32'hE1));
        end

        // Reset during requester 0's second word: that word is dropped and 0 wins again.
        doReset();
        for (int w = 0; w < 4; w++) wq[0].push_back('{last: 1'b0, data: DW'(32'hB0 + w)});
        drive();
        waitLog(1, 20, "rst_pre");
        rst_n = 1'b0;
        wq[1].push_back('{last: 1'b1, data: 32'hBB});
        drive();
        @(negedge clk);
        checkOutput("rst_cycle_wr", 64'(write_flag), 64'd0);
        checkOutput("rst_cycle_ack", 64'(ack), 64'd0);
        applyStimulus();
        rst_n = 1'b1;
        waitLog(2, 20, "rst_post");
        if (log_cyc.size() >= 2) begin
            checkOutput("rst_own", 64'(log_own[1]), 64'd0);
            checkOutput("rst_dat", 64'(log_dat[1]), 64'(32'hB1));
        end

        // Randomized traffic: pushes, withdrawals, FIFO stalls and occasional resets.
        doReset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(3) == 0 && wq[i].size() < 3)
                    wq[i].push_back('{last: ($urandom_range(2) == 0), data: DW'($urandom)});
                if ($urandom_range(19) == 0) en[i] = ~en[i];
            end
            fifo_full = ($urandom_range(4) == 0);
            rst_n = ($urandom_range(99) != 0);
            applyStimulus();
        end
        rst_n = 1'b1;
        fifo_full = 1'b0;
        applyStimulus();
        applyStimulus();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
